// File: rtl/tlp_rxcpl_pndgrd_match.sv
// rtl/tlp_rxcpl_pndgrd_match.sv - pending-read header match and completion placement tracker
// Optional completion timeout: define TLP_CPL_TIMEOUT_EN.
module tlp_rxcpl_pndgrd_match
`ifdef TLP_CPL_TIMEOUT_EN
#(
    parameter int C_TIMEOUT_CYCLES = 65535
)
`endif
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RxPndgRdFifoEmpty,
    input  logic [56:0] RxPndgRdFifoDato,
    output logic        RxPndgRdFifoRdReq,
    input  logic        CplValid,
    output logic        CplReady,
    input  logic [7:0]  CplTag,
    input  logic [2:0]  CplStatus,
    input  logic [9:0]  CplLenDw,
    output logic        DstValid,
    input  logic        DstReady,
    output logic [38:0] DstAddr,
    output logic [10:0] DstLenDw,
    output logic        DstDiscard,
    output logic        RdDone,
    output logic        CplErr,
    output logic        CplTimeout
);
    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t      state, stateNext;
    logic [38:0] curAddr;
    logic [10:0] remDw;
    logic [7:0]  curTag;
    logic [10:0] cplLen;
    logic        accept, tagOk, good, lastCpl, retire, tmoHit;

    assign cplLen   = (CplLenDw == 10'd0) ? 11'd1024 : {1'b0, CplLenDw};
    assign CplReady = (state == ACTIVE) && (!DstValid || DstReady);
    // Gated by rst_n so the pop strobe drops the instant reset asserts.
    assign RxPndgRdFifoRdReq = rst_n && (state == IDLE) && !RxPndgRdFifoEmpty;

    assign accept  = CplValid && CplReady;
    assign tagOk   = (CplTag == curTag);
    assign good    = tagOk && (CplStatus == 3'b000) && (cplLen <= remDw);
    assign lastCpl = good && (cplLen == remDw);
    // A foreign tag is not ours to retire; any other failure kills the read.
    assign retire  = accept && (lastCpl || (tagOk && !good));

`ifdef TLP_CPL_TIMEOUT_EN
    localparam int TmoW = $clog2(C_TIMEOUT_CYCLES + 1);
    logic [TmoW-1:0] tmoCnt;

    assign tmoHit = (state == ACTIVE) && !accept && (tmoCnt == TmoW'(C_TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmoCnt <= '0;
        end else if (RxPndgRdFifoRdReq || accept) begin
            tmoCnt <= '0;
        end else if (state == ACTIVE) begin
            tmoCnt <= tmoCnt + 1'b1;
        end
    end
`else
    assign tmoHit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (!RxPndgRdFifoEmpty) stateNext = ACTIVE;
            ACTIVE:  if (retire || tmoHit) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            curAddr    <= '0;
            remDw      <= '0;
            curTag     <= '0;
            DstValid   <= 1'b0;
            DstAddr    <= '0;
            DstLenDw   <= '0;
            DstDiscard <= 1'b0;
            RdDone     <= 1'b0;
            CplErr     <= 1'b0;
            CplTimeout <= 1'b0;
        end else begin
            RdDone     <= 1'b0;
            CplErr     <= 1'b0;
            CplTimeout <= tmoHit;
            if (RxPndgRdFifoRdReq) begin
                curAddr <= RxPndgRdFifoDato[56:18];
                remDw   <= (RxPndgRdFifoDato[17:8] == 10'd0) ? 11'd1024 : {1'b0, RxPndgRdFifoDato[17:8]};
                curTag  <= RxPndgRdFifoDato[7:0];
            end
            if (accept) begin
                DstValid   <= 1'b1;
                DstAddr    <= curAddr;
                DstLenDw   <= cplLen;
                DstDiscard <= !good;
                if (good) begin
                    curAddr <= curAddr + {26'd0, cplLen, 2'b00};
                    remDw   <= remDw - cplLen;
                    RdDone  <= lastCpl;
                end else begin
                    CplErr <= 1'b1;
                end
            end else if (DstReady) begin
                DstValid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_tlp_rxcpl_pndgrd_match.sv
// tb/tb_tlp_rxcpl_pndgrd_match.sv - self-checking bench for tlp_rxcpl_pndgrd_match
module tb_tlp_rxcpl_pndgrd_match;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        RxPndgRdFifoEmpty;
    logic [56:0] RxPndgRdFifoDato;
    logic        RxPndgRdFifoRdReq;
    logic        CplValid;
    logic        CplReady;
    logic [7:0]  CplTag;
    logic [2:0]  CplStatus;
    logic [9:0]  CplLenDw;
    logic        DstValid;
    logic        DstReady;
    logic [38:0] DstAddr;
    logic [10:0] DstLenDw;
    logic        DstDiscard;
    logic        RdDone;
    logic        CplErr;
    logic        CplTimeout;

    always #5 clk = ~clk;

`ifdef TLP_CPL_TIMEOUT_EN
    tlp_rxcpl_pndgrd_match #(.C_TIMEOUT_CYCLES(16)) dut (
`else
    tlp_rxcpl_pndgrd_match dut (
`endif
        .clk(clk), .rst_n(rst_n),
        .RxPndgRdFifoEmpty(RxPndgRdFifoEmpty), .RxPndgRdFifoDato(RxPndgRdFifoDato),
        .RxPndgRdFifoRdReq(RxPndgRdFifoRdReq),
        .CplValid(CplValid), .CplReady(CplReady), .CplTag(CplTag),
        .CplStatus(CplStatus), .CplLenDw(CplLenDw),
        .DstValid(DstValid), .DstReady(DstReady), .DstAddr(DstAddr),
        .DstLenDw(DstLenDw), .DstDiscard(DstDiscard),
        .RdDone(RdDone), .CplErr(CplErr), .CplTimeout(CplTimeout)
    );

    typedef struct packed {logic [38:0] addr; logic [9:0] len; logic [7:0] tag;} hdr_t;
    typedef struct packed {logic [7:0] tag; logic [2:0] status; logic [9:0] len;} cpl_t;
    typedef struct packed {logic [38:0] addr; logic [10:0] len; logic discard;} desc_t;

    hdr_t  hdrQ[$], mHdr[$];
    cpl_t  cplQ[$], mCpl[$];
    desc_t gotQ[$], expQ[$];

    int checks = 0, failures = 0;
    int doneCnt = 0, errCnt = 0, tmoCnt = 0, popCnt = 0, emptyPopCnt = 0, cyc = 0;
    int lastPopCyc = 0, firstAccCyc = -1, firstDstCyc = -1, tmoCyc = -1;
    bit holdReady = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        RxPndgRdFifoEmpty = (hdrQ.size() == 0);
        RxPndgRdFifoDato  = (hdrQ.size() != 0) ? {hdrQ[0].addr, hdrQ[0].len, hdrQ[0].tag} : 57'({$urandom, $urandom});
        CplValid  = (cplQ.size() != 0);
        CplTag    = (cplQ.size() != 0) ? cplQ[0].tag : 8'($urandom);
        CplStatus = (cplQ.size() != 0) ? cplQ[0].status : 3'($urandom);
        CplLenDw  = (cplQ.size() != 0) ? cplQ[0].len : 10'($urandom);
        DstReady  = holdReady ? 1'b0 : ($urandom_range(0, 3) != 0);
    endtask

    // Upstream FIFO, completion source and data-mover sink; handshakes sampled at negedge.
    initial begin
        bit popHs, cplHs;
        drive();
        forever begin
            @(negedge clk);
            cyc++;
            popHs = 1'b0;
            cplHs = 1'b0;
            if (rst_n) begin
                popHs = RxPndgRdFifoRdReq;
                cplHs = CplValid && CplReady;
                if (popHs) begin
                    popCnt++;
                    lastPopCyc = cyc;
                    if (RxPndgRdFifoEmpty) emptyPopCnt++;
                end
                if (cplHs && firstAccCyc < 0) firstAccCyc = cyc;
                if (DstValid && firstDstCyc < 0) firstDstCyc = cyc;
                if (DstValid && DstReady) gotQ.push_back('{DstAddr, DstLenDw, DstDiscard});
                if (RdDone) doneCnt++;
                if (CplErr) errCnt++;
                if (CplTimeout) begin tmoCnt++; tmoCyc = cyc; end
            end
            @(posedge clk);
            #1;
            if (popHs && hdrQ.size() != 0) hdrQ.delete(0);
            if (cplHs && cplQ.size() != 0) cplQ.delete(0);
            drive();
        end
    end

    // Reference: walk headers and completions in order, applying the match rules directly.
    task automatic runModel(output int eDone, output int eErr, output int ePop);
        bit act = 1'b0;
        logic [38:0] a = '0;
        logic [7:0] t = '0;
        int rem = 0, n, hi = 0, ci = 0;
        cpl_t c;
        eDone = 0; eErr = 0; ePop = 0;
        expQ.delete();
        forever begin
            if (!act) begin
                if (hi >= mHdr.size()) break;
                a = mHdr[hi].addr;
                rem = (mHdr[hi].len == 0) ? 1024 : int'(mHdr[hi].len);
                t = mHdr[hi].tag;
                hi++; ePop++; act = 1'b1;
            end
            if (ci >= mCpl.size()) break;
            c = mCpl[ci++];
            n = (c.len == 0) ? 1024 : int'(c.len);
            if (c.tag == t && c.status == 3'd0 && n <= rem) begin
                expQ.push_back('{a, 11'(n), 1'b0});
                a = a + 39'(n * 4);
                rem -= n;
                if (rem == 0) begin eDone++; act = 1'b0; end
            end else begin
                expQ.push_back('{a, 11'(n), 1'b1});
                eErr++;
                if (c.tag == t) act = 1'b0;
            end
        end
    endtask

    task automatic runScenario(input string name, input int stall);
        int eDone, eErr, ePop, b, bad, nCmp;
        logic [38:0] a0;
        runModel(eDone, eErr, ePop);
        doneCnt = 0; errCnt = 0; popCnt = 0; gotQ.delete();
        firstAccCyc = -1; firstDstCyc = -1;
        if (stall > 0) holdReady = 1'b1;
        foreach (mHdr[i]) hdrQ.push_back(mHdr[i]);
        foreach (mCpl[i]) cplQ.push_back(mCpl[i]);
        if (stall > 0) begin
            b = 0;
            while (!DstValid && b < 100) begin @(negedge clk); b++; end
            check({name, "_stall_setup"}, DstValid, 1);
            a0 = DstAddr;
            bad = 0;
            repeat (stall) begin
                @(negedge clk);
                if (CplReady || !DstValid || DstAddr !== a0) bad++;
            end
            check({name, "_stall_hold"}, bad, 0);
            check({name, "_cpl_waiting"}, cplQ.size(), mCpl.size() - 1);
            holdReady = 1'b0;
        end
        b = 0;
        while ((gotQ.size() < expQ.size() || cplQ.size() != 0 || hdrQ.size() != 0 || DstValid) && b < 5000) begin
            @(negedge clk);
            b++;
        end
        repeat (3) @(negedge clk);
        check({name, "_drain_bound"}, b < 5000, 1);
        check({name, "_ndesc"}, gotQ.size(), expQ.size());
        nCmp = (gotQ.size() < expQ.size()) ? gotQ.size() : expQ.size();
        for (int i = 0; i < nCmp; i++) check($sformatf("%s_desc%0d", name, i), gotQ[i], expQ[i]);
        check({name, "_rddone"}, doneCnt, eDone);
        check({name, "_cplerr"}, errCnt, eErr);
        check({name, "_pops"}, popCnt, ePop);
    endtask

    task automatic genRandom();
        int nRd, len, rem, n;
        logic [7:0] tg;
        mHdr.delete(); mCpl.delete();
        nRd = $urandom_range(1, 3);
        for (int r = 0; r < nRd; r++) begin
            tg  = 8'($urandom);
            len = ($urandom_range(0, 5) == 0) ? 1024 : $urandom_range(1, 64);
            mHdr.push_back('{39'({$urandom, $urandom}), 10'(len), tg});
            rem = len;
            while (rem > 0) begin
                if ($urandom_range(0, 5) == 0)
                    mCpl.push_back('{tg ^ 8'h5a, 3'($urandom), 10'($urandom_range(1, 8))});
                if ($urandom_range(0, 9) == 0) begin
                    if ($urandom_range(0, 1) == 0 || rem == 1024)
                        mCpl.push_back('{tg, 3'($urandom_range(1, 7)), 10'($urandom_range(1, 4))});
                    else
                        mCpl.push_back('{tg, 3'd0, 10'(rem + 1)});
                    break;
                end
                n = $urandom_range(1, (rem < 256) ? rem : 256);
                mCpl.push_back('{tg, 3'd0, 10'(n)});
                rem -= n;
            end
        end
    endtask

    initial begin
        int b;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {RxPndgRdFifoRdReq, CplReady, DstValid, DstDiscard, RdDone, CplErr, CplTimeout, DstAddr, DstLenDw}, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        mHdr.delete(); mCpl.delete();
        mHdr.push_back('{39'h1000, 10'd4, 8'd5});
        mCpl.push_back('{8'd5, 3'd0, 10'd4});
        runScenario("t1_single", 0);
        check("t1_pop_to_ready", firstAccCyc - lastPopCyc, 1);
        check("t1_accept_to_dst", firstDstCyc - firstAccCyc, 1);
        check("t1_idle_after", CplReady, 0);

        mHdr.delete(); mCpl.delete();
        mHdr.push_back('{39'h12_3456_7000, 10'd0, 8'd7});
        mCpl.push_back('{8'd7, 3'd0, 10'd512});
        mCpl.push_back('{8'd7, 3'd0, 10'd512});
        runScenario("t2_len1024", 0);
        if (gotQ.size() == 2) check("t2_second_addr", gotQ[1].addr, 39'h12_3456_7800);

        mHdr.delete(); mCpl.delete();
        mHdr.push_back('{39'h7F_FFFF_FFF0, 10'd16, 8'd2});
        mCpl.push_back('{8'd2, 3'd0, 10'd8});
        mCpl.push_back('{8'd2, 3'd0, 10'd8});
        runScenario("t2b_wrap", 0);

        mHdr.delete(); mCpl.delete();
        mHdr.push_back('{39'h4000, 10'd2, 8'd5});
        mCpl.push_back('{8'd6, 3'd0, 10'd2});
        mCpl.push_back('{8'd5, 3'd0, 10'd2});
        runScenario("t3_badtag", 0);

        mHdr.delete(); mCpl.delete();
        mHdr.push_back('{39'h5000, 10'd2, 8'd9});
        mHdr.push_back('{39'h6000, 10'd1, 8'd10});
        mCpl.push_back('{8'd9, 3'd0, 10'd4});
        mCpl.push_back('{8'd10, 3'd0, 10'd1});
        runScenario("t4_overrun", 0);

        mHdr.delete(); mCpl.delete();
        mHdr.push_back('{39'h7000, 10'd8, 8'd3});
        mCpl.push_back('{8'd3, 3'd0, 10'd4});
        mCpl.push_back('{8'd3, 3'd0, 10'd4});
        runScenario("t5_stall", 10);

        for (int k = 0; k < 8; k++) begin
            genRandom();
            runScenario($sformatf("rand%0d", k), 0);
        end

`ifdef TLP_CPL_TIMEOUT_EN
        tmoCnt = 0; tmoCyc = -1; doneCnt = 0;
        hdrQ.push_back('{39'h8000, 10'd4, 8'd1});
        b = 0;
        while (tmoCnt == 0 && b < 100) begin @(negedge clk); b++; end
        repeat (3) @(negedge clk);
        check("t6_timeout_seen", tmoCnt, 1);
        check("t6_timeout_cycle", tmoCyc - lastPopCyc, 17);
        check("t6_idle_after", CplReady, 0);
        check("t6_no_rddone", doneCnt, 0);
`else
        hdrQ.push_back('{39'h8000, 10'd4, 8'd1});
        repeat (60) @(negedge clk);
        check("t6_still_waiting", CplReady, 1);
        doneCnt = 0;
        cplQ.push_back('{8'd1, 3'd0, 10'd4});
        b = 0;
        while (doneCnt == 0 && b < 100) begin @(negedge clk); b++; end
        check("t6_late_done", doneCnt, 1);
        check("t6_no_timeout", tmoCnt, 0);
`endif

        holdReady = 1'b1;
        hdrQ.push_back('{39'h55_5555_5554, 10'd4, 8'd1});
        hdrQ.push_back('{39'h9000, 10'd4, 8'd2});
        cplQ.push_back('{8'd1, 3'd0, 10'd2});
        b = 0;
        while (!DstValid && b < 50) begin @(negedge clk); b++; end
        check("t6_rst_setup", {DstValid, RxPndgRdFifoEmpty}, 2'b10);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_outputs", {RxPndgRdFifoRdReq, CplReady, DstValid, DstDiscard, RdDone, CplErr, CplTimeout, DstAddr, DstLenDw}, 0);
        hdrQ.delete(); cplQ.delete();
        holdReady = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("t6_idle_post_reset", CplReady, 0);
        check("never_pop_empty", emptyPopCnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
